// File: rtl/i2s_out_serializer_pkg.sv
// Shared constants for the I2S output serializer: frame geometry and default sizing.
package i2s_out_serializer_pkg;
  localparam int SAMPLE_W           = 16;
  localparam int FRAME_BITS         = 32;
  localparam int BITS_PER_CH        = 16;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int BIT_CNT_W          = $clog2(FRAME_BITS);
  localparam int BIT_IDX_W          = $clog2(BITS_PER_CH);
endpackage

// File: rtl/i2s_out_serializer_fifo.sv
// Sample buffer: single-clock FIFO with first-word show-ahead on rdata.
module sample_fifo
  import i2s_out_serializer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = i2s_out_serializer_pkg::SAMPLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/i2s_out_serializer.sv
// I2S (Philips) transmitter: bclk/lr_clk generation, frame bit counter and serial data select.
module i2s_out_serializer
  import i2s_out_serializer_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int SAMPLE_W   = i2s_out_serializer_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          bclk_period,
  input  logic                sample_vld,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                lr_clk,
  output logic                bclk,
  output logic                dout,
  output logic                overflow,
  output logic                underflow
);
  logic [7:0]             hp_cnt;
  logic [7:0]             hp_last;
  logic                   half_wrap;
  logic                   fall;
  logic                   frame_load;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BIT_CNT_W-1:0]   bit_nxt;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [SAMPLE_W-1:0]    fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [SAMPLE_W-1:0]    frame_sample;
  logic [BITS_PER_CH-1:0] word;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sample_vld),
    .pop   (frame_load),
    .wdata (sample),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A period of 0 behaves as 1; >= lets a shortened period wrap at once instead of running to 255.
  assign hp_last   = (bclk_period == 8'd0) ? 8'd0 : bclk_period - 8'd1;
  assign half_wrap = (hp_cnt >= hp_last);
  assign fall      = half_wrap && bclk;
  assign bit_nxt   = bit_cnt + BIT_CNT_W'(1);
  assign frame_load = fall && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));

  generate
    if (SAMPLE_W >= BITS_PER_CH) begin : g_word_msbs
      assign word = frame_sample[SAMPLE_W-1 -: BITS_PER_CH];
    end else begin : g_word_pad
      assign word = {frame_sample, {(BITS_PER_CH - SAMPLE_W){1'b0}}};
    end
  endgenerate

  // One-bit delay, MSB first, both channels: bit n of the frame carries word[(16 - n) mod 16].
  // At n = 0 frame_sample still holds the previous frame, giving its LSB as the delayed right bit.
  assign bit_idx = '0 - bit_nxt[BIT_IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt <= '0;
      bclk   <= 1'b0;
    end else if (half_wrap) begin
      hp_cnt <= '0;
      bclk   <= ~bclk;
    end else begin
      hp_cnt <= hp_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '1;
      lr_clk  <= 1'b0;
      dout    <= 1'b0;
    end else if (fall) begin
      bit_cnt <= bit_nxt;
      lr_clk  <= bit_nxt[BIT_CNT_W-1];
      dout    <= word[bit_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sample <= '0;
    end else if (frame_load && !fifo_empty) begin
      frame_sample <= fifo_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (sample_vld && fifo_full && !frame_load) overflow  <= 1'b1;
      if (frame_load && fifo_empty)               underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2s_out_serializer.sv
// Self-checking bench for i2s_out_serializer: reference model + frame scoreboard, row table and corner sequences.
module tb_i2s_out_serializer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bclk_period = 8'd1;
  logic        sample_vld = 1'b0;
  logic [15:0] sample = '0;
  logic        lr_clk, bclk, dout, overflow, underflow;

  i2s_out_serializer #(
    .FIFO_DEPTH (DEPTH),
    .SAMPLE_W   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bclk_period (bclk_period),
    .sample_vld  (sample_vld),
    .sample      (sample),
    .lr_clk      (lr_clk),
    .bclk        (bclk),
    .dout        (dout),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int          p_eff = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  // Reference model, evaluated on every rising edge with pre-edge inputs.
  logic [15:0] mq[$];
  logic [15:0] frame_exp[$];
  logic [15:0] mfs = '0;
  int          mcnt = 0;
  logic        mbclk = 1'b0;
  int          mbit = 31;
  logic        movf = 1'b0;
  logic        munf = 1'b0;
  logic        m_load = 1'b0;

  initial begin
    int   p;
    logic fall;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        frame_exp.delete();
        mfs = '0; mcnt = 0; mbclk = 1'b0; mbit = 31;
        movf = 1'b0; munf = 1'b0; m_load = 1'b0;
      end else begin
        p = (bclk_period == 8'd0) ? 1 : int'(bclk_period);
        fall = 1'b0;
        if (mcnt >= p - 1) begin
          mcnt = 0;
          fall = mbclk;
          mbclk = ~mbclk;
        end else begin
          mcnt++;
        end
        m_load = fall && (mbit == 31);
        if (fall) mbit = (mbit + 1) % 32;
        if (m_load) begin
          if (mq.size() > 0) mfs = mq.pop_front();
          else               munf = 1'b1;
          frame_exp.push_back(mfs);
        end
        if (sample_vld) begin
          if (mq.size() < DEPTH) mq.push_back(sample);
          else                   movf = 1'b1;
        end
      end
    end
  end

  // Monitor: decodes the serial stream on the opposite clock edge and scores frames.
  int          tb_bit = 31;
  logic        pbclk = 1'b0, plr = 1'b0, have_cur = 1'b0;
  logic        hp_seen = 1'b0, lr_seen = 1'b0;
  int          hp_len = 0, lr_len = 0;
  logic [15:0] lword = '0, rword = '0, cur_exp = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tb_bit = 31; pbclk = 1'b0; plr = 1'b0; have_cur = 1'b0;
        hp_seen = 1'b0; lr_seen = 1'b0; hp_len = 0; lr_len = 0;
      end else begin
        hp_len++;
        lr_len++;
        if (bclk !== pbclk) begin
          if (hp_seen) check("bclk_half_period", 32'(hp_len), 32'(p_eff));
          hp_seen = 1'b1;
          hp_len = 0;
        end
        if (!plr && lr_clk) begin
          if (lr_seen) check("lr_clk_period", 32'(lr_len), 32'(64 * p_eff));
          lr_seen = 1'b1;
          lr_len = 0;
        end
        if (pbclk && !bclk) begin
          tb_bit = (tb_bit + 1) % 32;
          check("lr_clk_at_bit", 32'(lr_clk), 32'(tb_bit >= 16));
          if (tb_bit >= 1 && tb_bit <= 16) lword = {lword[14:0], dout};
          else                             rword = {rword[14:0], dout};
          if (tb_bit == 16 && have_cur) check("left_word", 32'(lword), 32'(cur_exp));
          if (tb_bit == 0) begin
            if (have_cur) check("right_word", 32'(rword), 32'(cur_exp));
            if (frame_exp.size() == 0) begin
              timeout("frame_scoreboard");
              have_cur = 1'b0;
            end else begin
              cur_exp = frame_exp.pop_front();
              have_cur = 1'b1;
            end
            check("overflow_at_load", 32'(overflow), 32'(movf));
            check("underflow_at_load", 32'(underflow), 32'(munf));
          end
        end
        pbclk = bclk;
        plr = lr_clk;
      end
    end
  end

  // Stimulus helpers; all are entered and left 1 time unit after a rising edge.
  task automatic do_reset(input logic [7:0] p);
    rst_n = 1'b0;
    sample_vld = 1'b0;
    bclk_period = p;
    p_eff = (p == 8'd0) ? 1 : int'(p);
    repeat (3) @(posedge clk);
    #1;
    check("rst_bclk", 32'(bclk), 32'd0);
    check("rst_lr_clk", 32'(lr_clk), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [15:0] v);
    sample_vld = 1'b1;
    sample = v;
    @(posedge clk);
    #1;
    sample_vld = 1'b0;
  endtask

  task automatic wait_load(input string name);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (m_load) return;
    end
    timeout(name);
  endtask

  task automatic run_frames(input int n);
    repeat (n * 64 * p_eff) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  period;
    int          pre;
    int          n;
    logic [15:0] s [5];
    logic        unf_first;
    logic        ovf;
    logic        unf;
    int          frames;
  } row_t;

  row_t rows [6];

  initial begin
    logic found;
    rows[0] = '{period: 8'd2, pre: 0, n: 0, s: '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                unf_first: 1'b1, ovf: 1'b0, unf: 1'b1, frames: 2};
    rows[1] = '{period: 8'd1, pre: 1, n: 1, s: '{16'h8001, 16'h0, 16'h0, 16'h0, 16'h0},
                unf_first: 1'b0, ovf: 1'b0, unf: 1'b1, frames: 2};
    rows[2] = '{period: 8'd3, pre: 0, n: 5, s: '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005},
                unf_first: 1'b1, ovf: 1'b1, unf: 1'b1, frames: 6};
    rows[3] = '{period: 8'd2, pre: 1, n: 1, s: '{16'h1234, 16'h0, 16'h0, 16'h0, 16'h0},
                unf_first: 1'b0, ovf: 1'b0, unf: 1'b1, frames: 2};
    rows[4] = '{period: 8'd4, pre: 0, n: 4, s: '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h7FFF, 16'h0},
                unf_first: 1'b1, ovf: 1'b0, unf: 1'b1, frames: 5};
    rows[5] = '{period: 8'd1, pre: 1, n: 3, s: '{16'h8000, 16'h0001, 16'hC3C3, 16'h0, 16'h0},
                unf_first: 1'b0, ovf: 1'b0, unf: 1'b1, frames: 5};

    #1;
    foreach (rows[r]) begin
      do_reset(rows[r].period);
      for (int i = 0; i < rows[r].pre; i++) push(rows[r].s[i]);
      wait_load("row_first_load");
      check("row_underflow_first_load", 32'(underflow), 32'(rows[r].unf_first));
      for (int i = rows[r].pre; i < rows[r].n; i++) push(rows[r].s[i]);
      run_frames(rows[r].frames);
      check("row_overflow_final", 32'(overflow), 32'(rows[r].ovf));
      check("row_underflow_final", 32'(underflow), 32'(rows[r].unf));
    end

    // Full FIFO: push lands in the same cycle as the frame-load pop.
    do_reset(8'd1);
    wait_load("full_first_load");
    for (int i = 0; i < 4; i++) push(16'h1111 * 16'(i + 1));
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (mbit == 31 && mbclk && mcnt >= p_eff - 1) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!found) timeout("full_pushpop_align");
    push(16'h5555);
    check("full_pushpop_overflow", 32'(overflow), 32'd0);
    run_frames(6);
    check("full_pushpop_overflow_final", 32'(overflow), 32'd0);
    check("full_pushpop_underflow_final", 32'(underflow), 32'd1);

    // Reset in the right channel with data still buffered.
    do_reset(8'd2);
    wait_load("midrst_first_load");
    push(16'hBEEF);
    push(16'h0F0F);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      #2;
      if (tb_bit == 20) found = 1'b1;
    end
    if (!found) timeout("midrst_bit20");
    check("midrst_lr_before", 32'(lr_clk), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_bclk", 32'(bclk), 32'd0);
    check("midrst_lr_clk", 32'(lr_clk), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_underflow", 32'(underflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_load("midrst_load_after");
    check("midrst_underflow_empty", 32'(underflow), 32'd1);
    run_frames(2);
    check("midrst_overflow_final", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
